// File: rtl/fib_sequencer.sv
// Control/register stage in front of the combinational ALU of the Fibonacci calculator.
// Sequences opcodes/operands each cycle, captures ALU results and returns F(n) mod 2^SIZE.
`timescale 1ns/1ps
module fib_sequencer #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] n,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] result,
    output logic            overflow,
    output logic [2:0]      alu_opcode,
    output logic [SIZE-1:0] alu_in1,
    output logic [SIZE-1:0] alu_in2,
    input  logic [SIZE-1:0] alu_out,
    input  logic            alu_zero
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_INIT_A,
        S_INIT_B,
        S_DEC,
        S_ADD,
        S_MOVE_A,
        S_MOVE_B,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_ONE  = 3'b001;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_PSB  = 3'b111;

    state_t          state_q, state_d;
    logic [SIZE-1:0] n_q, n_d;
    logic [SIZE-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0] a_q, a_d;
    logic [SIZE-1:0] b_q, b_d;
    logic [SIZE-1:0] t_q, t_d;
    logic [SIZE-1:0] result_q, result_d;
    logic            overflow_q, overflow_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // ALU drive depends only on state and registers, never on alu_out.
    always_comb begin
        alu_opcode = OP_ZERO;
        alu_in1    = '0;
        alu_in2    = '0;
        case (state_q)
            S_LOAD:   begin alu_opcode = OP_PASS; alu_in1 = n_q;   end
            S_INIT_A: begin alu_opcode = OP_ZERO;                  end
            S_INIT_B: begin alu_opcode = OP_ONE;                   end
            S_DEC:    begin alu_opcode = OP_DEC;  alu_in1 = cnt_q; end
            S_ADD:    begin alu_opcode = OP_ADD;  alu_in1 = a_q; alu_in2 = b_q; end
            S_MOVE_A: begin alu_opcode = OP_PSB;  alu_in2 = b_q;   end
            S_MOVE_B: begin alu_opcode = OP_PASS; alu_in1 = t_q;   end
            default:  ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        t_d        = t_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d        = n;
                    result_d   = '0;
                    overflow_d = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d = alu_out;
                if (alu_zero) begin
                    result_d = '0;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_INIT_A;
                end
            end
            S_INIT_A: begin
                a_d     = alu_out;
                state_d = S_INIT_B;
            end
            S_INIT_B: begin
                b_d     = alu_out;
                state_d = S_DEC;
            end
            S_DEC: begin
                cnt_d = alu_out;
                if (alu_zero) begin
                    result_d = b_q;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                t_d = alu_out;
                // An unsigned sum that wrapped is smaller than either addend.
                if (alu_out < a_q) overflow_d = 1'b1;
                state_d = S_MOVE_A;
            end
            S_MOVE_A: begin
                a_d     = alu_out;
                state_d = S_MOVE_B;
            end
            S_MOVE_B: begin
                b_d     = alu_out;
                state_d = S_DEC;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            t_q        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            t_q        <= t_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fib_sequencer.sv
// Scoreboard bench for fib_sequencer: a small ALU model closes the loop, and a
// Fibonacci reference computed with plain integers predicts result, overflow and timing.
`timescale 1ns/1ps
module tb_fib_sequencer;
    localparam int SIZE = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [SIZE-1:0] n;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] result;
    logic            overflow;
    logic [2:0]      alu_opcode;
    logic [SIZE-1:0] alu_in1;
    logic [SIZE-1:0] alu_in2;
    logic [SIZE-1:0] alu_out;
    logic            alu_zero;

    fib_sequencer #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n          (n),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .overflow   (overflow),
        .alu_opcode (alu_opcode),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    // Combinational ALU the sequencer expects downstream.
    always_comb begin
        alu_out = '0;
        case (alu_opcode)
            3'b000:  alu_out = '0;
            3'b001:  alu_out = 4'd1;
            3'b011:  alu_out = alu_in1 - 4'd1;
            3'b100:  alu_out = alu_in1;
            3'b110:  alu_out = alu_in1 + alu_in2;
            3'b111:  alu_out = alu_in2;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         nidx;
        logic [3:0] res;
        logic       ovf;
        int         done_cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] last_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // True Fibonacci value; the result is its low SIZE bits and the run overflowed
    // exactly when the true value no longer fits.
    function automatic exp_t model(input int nn, input int accept_edge);
        exp_t  e;
        longint fa = 0, fb = 1, tmp;
        for (int i = 0; i < nn; i++) begin
            tmp = fa + fb;
            fa  = fb;
            fb  = tmp;
        end
        e.nidx     = nn;
        e.res      = 4'(fa % 16);
        e.ovf      = (fa >= 16);
        e.done_cyc = accept_edge + ((nn == 0) ? 1 : 4 * nn);
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic issue(input int nn);
        check("result_hold", {28'b0, result}, {28'b0, last_res});
        n     = 4'(nn);
        start = 1'b1;
        sb_q.push_back(model(nn, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        n     = 4'($urandom);
    endtask

    task automatic wait_empty(input int budget);
        int i = 0;
        while (sb_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("drain_timeout", sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk);
    endtask

    // While running, randomly pulse start with random n; all of it must be ignored.
    task automatic run_noisy(input int nn, input int budget);
        int i = 0;
        issue(nn);
        while (sb_q.size() != 0 && i < budget) begin
            start = busy && ($urandom_range(0, 3) == 0);
            n     = 4'($urandom);
            @(negedge clk);
            i++;
        end
        start = 1'b0;
        check("noisy_timeout", sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", {31'b0, done}, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("result_n%0d", e.nidx), {28'b0, result}, {28'b0, e.res});
                check($sformatf("overflow_n%0d", e.nidx), {31'b0, overflow}, {31'b0, e.ovf});
                check($sformatf("latency_n%0d", e.nidx), cyc, e.done_cyc);
                check("done_opcode", {29'b0, alu_opcode}, 0);
                check("done_busy", {31'b0, busy}, 0);
                last_res = e.res;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete (t=%0t)", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] tr1 [4];
        logic       all_busy;
        int         list [6];
        tr1  = '{3'b100, 3'b000, 3'b001, 3'b011};
        list = '{8, 15, 2, 7, 3, 0};

        rst   = 1'b1;
        start = 1'b0;
        n     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_result", {28'b0, result}, 0);
        check("rst_overflow", {31'b0, overflow}, 0);
        check("rst_opcode", {29'b0, alu_opcode}, 0);
        @(negedge clk);

        issue(0);
        check("trace_n0_0", {29'b0, alu_opcode}, {29'b0, 3'b100});
        wait_empty(20);

        issue(1);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            check($sformatf("trace_n1_%0d", i), {29'b0, alu_opcode}, {29'b0, tr1[i]});
        end
        wait_empty(20);

        issue(7);
        all_busy = busy;
        for (int i = 1; i < 27; i++) begin
            @(negedge clk);
            all_busy = all_busy & busy;
        end
        check("busy_n7", {31'b0, all_busy}, 1);
        wait_empty(20);

        foreach (list[i]) begin
            issue(list[i]);
            wait_empty(100);
        end

        // Start pulse with a different n while running must be ignored.
        issue(7);
        repeat (3) @(negedge clk);
        n     = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty(100);

        // Reset mid-run aborts without a done pulse.
        issue(7);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        last_res = '0;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        check("abort_result", {28'b0, result}, 0);
        check("abort_overflow", {31'b0, overflow}, 0);
        check("abort_opcode", {29'b0, alu_opcode}, 0);
        check("abort_in1", {28'b0, alu_in1}, 0);
        repeat (40) @(negedge clk);
        check("abort_no_done", {31'b0, done}, 0);
        issue(5);
        wait_empty(100);

        for (int r = 0; r < 25; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_noisy($urandom_range(0, 15), 100);
        end

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
